// File: rtl/psum_channel_sequencer.sv
// Tags the conv-engine result stream with pixel index and first/last-channel flags
// for the partial-sum accumulator, spacing same-pixel writes and reporting row/pass completion.
module psum_channel_sequencer #(
  parameter int MAX_WIDTH = 512,
  localparam int PW = $clog2(MAX_WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [PW:0]   cfg_width,
  input  logic [15:0]   cfg_ch_groups,
  input  logic [15:0]   cfg_rows,
  input  logic [31:0]   in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [31:0]   acc_data,
  output logic          acc_valid,
  output logic          acc_first,
  output logic          acc_last,
  output logic [PW-1:0] acc_pixel_idx,
  output logic          busy,
  output logic          row_done,
  output logic          done,
  output logic          cfg_error
);

  typedef enum logic [2:0] {IDLE, RUN, GAP, DRAIN, DONE} state_t;

  localparam logic [PW:0] MAX_W = MAX_WIDTH[PW:0];
  localparam logic [PW:0] ONE_W = {{PW{1'b0}}, 1'b1};

  state_t        state, next_state;
  logic [PW:0]   width;
  logic [15:0]   ch_groups, rows;
  logic [PW-1:0] pix;
  logic [15:0]   ch, row;
  logic          pass_end, drain_cnt;
  logic          hs, cfg_ok, start_ok;
  logic          pix_last, ch_last, row_last, final_beat, width_one;

  assign cfg_ok     = (cfg_width != '0) && (cfg_width <= MAX_W) &&
                      (cfg_ch_groups != 16'd0) && (cfg_rows != 16'd0);
  assign start_ok   = (state == IDLE) && start && cfg_ok;
  assign hs         = in_valid && (state == RUN);
  assign pix_last   = ({1'b0, pix} == (width - ONE_W));
  assign ch_last    = (ch == (ch_groups - 16'd1));
  assign row_last   = (row == (rows - 16'd1));
  assign final_beat = pix_last && ch_last && row_last;
  assign width_one  = (width == ONE_W);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    busy       = (state != IDLE);
    done       = 1'b0;
    case (state)
      IDLE:  if (start && cfg_ok) next_state = RUN;
      RUN: begin
        in_ready = 1'b1;
        // A single-pixel row would hit the same accumulator slot on consecutive beats.
        if (hs) begin
          if (width_one)       next_state = GAP;
          else if (final_beat) next_state = DRAIN;
        end
      end
      GAP:   next_state = pass_end ? DRAIN : RUN;
      DRAIN: if (drain_cnt) next_state = DONE;
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_data      <= '0;
      acc_valid     <= 1'b0;
      acc_first     <= 1'b0;
      acc_last      <= 1'b0;
      acc_pixel_idx <= '0;
      row_done      <= 1'b0;
      cfg_error     <= 1'b0;
      width         <= '0;
      ch_groups     <= '0;
      rows          <= '0;
      pix           <= '0;
      ch            <= '0;
      row           <= '0;
      pass_end      <= 1'b0;
      drain_cnt     <= 1'b0;
    end else begin
      acc_valid <= hs;
      row_done  <= hs && pix_last && ch_last;
      cfg_error <= (state == IDLE) && start && !cfg_ok;
      drain_cnt <= (state == DRAIN) && !drain_cnt;
      if (hs) begin
        acc_data      <= in_data;
        acc_pixel_idx <= pix;
        acc_first     <= (ch == 16'd0);
        acc_last      <= ch_last;
      end
      if (start_ok) begin
        width     <= cfg_width;
        ch_groups <= cfg_ch_groups;
        rows      <= cfg_rows;
        pix       <= '0;
        ch        <= '0;
        row       <= '0;
        pass_end  <= 1'b0;
      end else if (hs) begin
        if (pix_last) begin
          pix <= '0;
          if (ch_last) begin
            ch  <= 16'd0;
            row <= row + 16'd1;
            if (row_last) pass_end <= 1'b1;
          end else begin
            ch <= ch + 16'd1;
          end
        end else begin
          pix <= pix + 1'b1;
        end
      end
    end
  end

endmodule
